// File: rtl/mainmem_pkg.sv
// Shared definitions for the wait-state main-memory model: FSM state
// encoding, data word width and wait-counter width.
package mainmem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/mainmem_ws_if.sv
// Miss/writeback port between the data cache controller (master) and the
// main-memory model (slave). The request fields stay stable while
// memory_stb is high; memory_ack is a one-cycle completion pulse.
interface mainmem_ws_if
  import mainmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
);

  logic                  memory_stb;
  logic                  memory_we;
  logic [ADDR_WIDTH-1:0] memory_addr;
  logic [WORD_W-1:0]     memory_din;
  logic [WORD_W-1:0]     memory_dout;
  logic                  memory_ack;

  modport master (
    output memory_stb, memory_we, memory_addr, memory_din,
    input  memory_dout, memory_ack
  );

  modport slave (
    input  memory_stb, memory_we, memory_addr, memory_din,
    output memory_dout, memory_ack
  );

endinterface

// File: rtl/mainmem_array.sv
// Single-port 32-bit synchronous RAM, 2**ADDR_WIDTH words deep, with a
// write enable and a registered read port. The read register only loads
// when re is high, so it holds the last read word across writes and idles.
module mainmem_array
  import mainmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage write port.
  // NOTE: the storage array has no reset branch; clearing it would need a
  // write per word and would prevent mapping to a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read data; cleared by reset, otherwise held between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mainmem_ws.sv
// Word-organised main-memory model with programmable read/write wait
// states, serving the data cache miss/writeback port.
// Optional build macro MAINMEM_PROTO_CHECK_EN adds a simulation-only
// protocol monitor (early strobe drop, request fields changing while
// waiting) with a hierarchical error counter err_count.
module mainmem_ws
  import mainmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int RD_WAIT    = 3,
  parameter int WR_WAIT    = 2
) (
  input logic         clk,
  input logic         rst,
  mainmem_ws_if.slave bus
);

  localparam logic [CNT_W-1:0] RD_W = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_W = CNT_W'(WR_WAIT);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  ack_q;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [WORD_W-1:0]     lat_din;

  logic [CNT_W-1:0]      sel_wait;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [WORD_W-1:0]     acc_din;
  logic                  commit;
  logic [WORD_W-1:0]     rdata;

  // Wait selection and array access source: a zero-wait request commits
  // straight from IDLE using the live fields, otherwise the latched ones.
  // NOTE: every signal gets a default before the conditional override so
  // no path leaves it unassigned (which would infer a latch).
  always_comb begin
    sel_wait = bus.memory_we ? WR_W : RD_W;
    acc_we   = lat_we;
    acc_addr = lat_addr;
    acc_din  = lat_din;
    if (state == ST_IDLE) begin
      acc_we   = bus.memory_we;
      acc_addr = bus.memory_addr;
      acc_din  = bus.memory_din;
    end
  end

  // The access edge: strobe still high, wait exhausted, and no reset
  // (reset wins over a coinciding commit, so a pending write is dropped).
  assign commit = !rst && bus.memory_stb &&
                  (((state == ST_IDLE) && (sel_wait == '0)) ||
                   ((state == ST_WAIT) && (cnt == '0)));

  mainmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (commit && acc_we),
    .re   (commit && !acc_we),
    .addr (acc_addr),
    .wdata(acc_din),
    .rdata(rdata)
  );

  assign bus.memory_dout = rdata;
  assign bus.memory_ack  = ack_q;

  // Request FSM. The counter holds the wait cycles still to go after the
  // current one, so WAIT lasts exactly W cycles and ack lands W+1 cycles
  // after the accepting cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ack_q    <= 1'b0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.memory_stb) begin
            lat_we   <= bus.memory_we;
            lat_addr <= bus.memory_addr;
            lat_din  <= bus.memory_din;
            if (sel_wait == '0) begin
              state <= ST_ACK;
              ack_q <= 1'b1;
            end else begin
              cnt   <= sel_wait - CNT_W'(1);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!bus.memory_stb) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            state <= ST_ACK;
            ack_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MAINMEM_PROTO_CHECK_EN
  logic [31:0] err_count;

  // Simulation monitor: flags an early strobe drop or request fields that
  // move while the request is waiting; the abort itself is handled above.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (state == ST_WAIT) begin
      if (!bus.memory_stb) begin
        $display("%0t mainmem_ws: protocol error early_stb_drop addr=%h",
                 $time, lat_addr);
        err_count <= err_count + 32'd1;
      end else if ((bus.memory_we != lat_we) ||
                   (bus.memory_addr != lat_addr) ||
                   (bus.memory_din != lat_din)) begin
        $display("%0t mainmem_ws: protocol error field_change addr=%h",
                 $time, lat_addr);
        err_count <= err_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mainmem_ws.sv
// Self-checking bench for mainmem_ws. Two instances: the default wait
// configuration (RD 3 / WR 2) and a zero-wait one (RD 0 / WR 0). A
// behavioural model (associative word array plus last-read register)
// predicts read data; ack timing is predicted from the latency rule
// "ack in cycle W+1 after the request cycle, one idle bubble after ack".
module tb_mainmem_ws;

  localparam int AW = 14;
  localparam int RD = 3;
  localparam int WR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mainmem_ws_if #(.ADDR_WIDTH(AW)) bus   ();
  mainmem_ws_if #(.ADDR_WIDTH(AW)) bus_z ();

  mainmem_ws #(.ADDR_WIDTH(AW), .RD_WAIT(RD), .WR_WAIT(WR)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  mainmem_ws #(.ADDR_WIDTH(AW), .RD_WAIT(0), .WR_WAIT(0)) dut_z (
    .clk(clk), .rst(rst), .bus(bus_z.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem_model [int];
  logic [31:0] model_dout [2];

  function automatic int key(input bit z, input logic [AW-1:0] a);
    return (int'(z) << AW) | int'(a);
  endfunction

  function automatic int wait_of(input bit z, input bit we);
    if (z) return 0;
    return we ? WR : RD;
  endfunction

  function automatic logic get_ack(input bit z);
    return z ? bus_z.memory_ack : bus.memory_ack;
  endfunction

  function automatic logic [31:0] get_dout(input bit z);
    return z ? bus_z.memory_dout : bus.memory_dout;
  endfunction

  task automatic drive(input bit z, input bit stb, input bit we,
                       input logic [AW-1:0] a, input logic [31:0] d);
    if (z) begin
      bus_z.memory_stb  = stb;
      bus_z.memory_we   = we;
      bus_z.memory_addr = a;
      bus_z.memory_din  = d;
    end else begin
      bus.memory_stb  = stb;
      bus.memory_we   = we;
      bus.memory_addr = a;
      bus.memory_din  = d;
    end
  endtask

  // One complete request with strobe dropped after the ack cycle; checks
  // ack and dout in every cycle from the request cycle to the bubble.
  task automatic do_req(input bit z, input bit we, input logic [AW-1:0] a,
                        input logic [31:0] d, input string name);
    int w;
    w = wait_of(z, we);
    @(posedge clk); #1;
    drive(z, 1'b1, we, a, d);
    for (int k = 0; k <= w + 2; k++) begin
      @(negedge clk);
      if (k == w + 1) begin
        if (we) mem_model[key(z, a)] = d;
        else    model_dout[z] = mem_model[key(z, a)];
      end
      vectors++;
      if (get_ack(z) !== (k == w + 1)) begin
        miscompares++;
        $display("FAIL %s ack cyc%0d: got %b want %b", name, k, get_ack(z), (k == w + 1));
      end
      vectors++;
      if (get_dout(z) !== model_dout[z]) begin
        miscompares++;
        $display("FAIL %s dout cyc%0d: got %h want %h", name, k, get_dout(z), model_dout[z]);
      end
      if (k == w + 1) begin
        @(posedge clk); #1;
        drive(z, 1'b0, we, a, d);
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int z = 0; z < 2; z++) begin
      vectors++;
      if (get_ack(z[0]) !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ack%0d: got %b want 0", z, get_ack(z[0]));
      end
      vectors++;
      if (get_dout(z[0]) !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_dout%0d: got %h want 00000000", z, get_dout(z[0]));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_dout[0] = 32'h0;
    model_dout[1] = 32'h0;
  endtask

  task automatic test_read_wait();
    do_req(0, 1, 14'h0000, 32'h0BADF00D, "pre_0000");
    do_req(0, 1, 14'h0005, 32'hDEADBEEF, "pre_0005");
    do_req(0, 1, 14'h0040, 32'h40404040, "pre_0040");
    do_req(0, 1, 14'h3FFF, 32'h3FFF0000, "pre_3fff");
    do_req(0, 0, 14'h0005, 32'h0, "read_0005");
    vectors++;
    if (bus.memory_dout !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL read_0005_value: got %h want deadbeef", bus.memory_dout);
    end
  endtask

  task automatic test_write_read();
    do_req(0, 1, 14'h0123, 32'h12345678, "write_0123");
    do_req(0, 0, 14'h0123, 32'h0, "read_0123");
    vectors++;
    if (bus.memory_dout !== 32'h12345678) begin
      miscompares++;
      $display("FAIL read_0123_value: got %h want 12345678", bus.memory_dout);
    end
  endtask

  // Two reads with strobe held high across the first ack.
  task automatic b2b(input bit z, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                     input string name);
    int w;
    bit exp;
    w = wait_of(z, 1'b0);
    @(posedge clk); #1;
    drive(z, 1'b1, 1'b0, a1, '0);
    for (int k = 0; k <= 2 * w + 4; k++) begin
      @(negedge clk);
      exp = (k == w + 1) || (k == 2 * w + 3);
      if (exp) model_dout[z] = mem_model[key(z, (k == w + 1) ? a1 : a2)];
      vectors++;
      if (get_ack(z) !== exp) begin
        miscompares++;
        $display("FAIL %s ack cyc%0d: got %b want %b", name, k, get_ack(z), exp);
      end
      vectors++;
      if (get_dout(z) !== model_dout[z]) begin
        miscompares++;
        $display("FAIL %s dout cyc%0d: got %h want %h", name, k, get_dout(z), model_dout[z]);
      end
      if (k == w + 1) begin
        @(posedge clk); #1;
        drive(z, 1'b1, 1'b0, a2, '0);
      end else if (k == 2 * w + 3) begin
        @(posedge clk); #1;
        drive(z, 1'b0, 1'b0, a2, '0);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_req(1, 1, 14'h0001, $urandom, "z_pre_0001");
    do_req(1, 1, 14'h0002, $urandom, "z_pre_0002");
    b2b(1, 14'h0001, 14'h0002, "b2b_zero");
    b2b(0, 14'h0005, 14'h0123, "b2b_wait");
  endtask

  task automatic test_abort();
`ifdef MAINMEM_PROTO_CHECK_EN
    logic [31:0] err_before;
    err_before = dut.err_count;
`endif
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 14'h0040, 32'hCAFEF00D);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 14'h0040, 32'hCAFEF00D);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.memory_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_ack cyc%0d: got %b want 0", k, bus.memory_ack);
      end
      vectors++;
      if (bus.memory_dout !== model_dout[0]) begin
        miscompares++;
        $display("FAIL abort_dout cyc%0d: got %h want %h", k, bus.memory_dout, model_dout[0]);
      end
    end
`ifdef MAINMEM_PROTO_CHECK_EN
    vectors++;
    if (dut.err_count - err_before !== 32'd1) begin
      miscompares++;
      $display("FAIL abort_err_count: got %0d want 1", dut.err_count - err_before);
    end
`endif
    do_req(0, 0, 14'h0040, 32'h0, "abort_readback");
    vectors++;
    if (bus.memory_dout !== 32'h40404040) begin
      miscompares++;
      $display("FAIL abort_readback_value: got %h want 40404040", bus.memory_dout);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 14'h3FFF, 32'hA5A5A5A5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b1, 14'h3FFF, 32'hA5A5A5A5);
    model_dout[0] = 32'h0;
    model_dout[1] = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.memory_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_ack cyc%0d: got %b want 0", k, bus.memory_ack);
      end
      vectors++;
      if (bus.memory_dout !== 32'h0) begin
        miscompares++;
        $display("FAIL rstmid_dout cyc%0d: got %h want 00000000", k, bus.memory_dout);
      end
    end
    do_req(0, 0, 14'h3FFF, 32'h0, "rstmid_readback");
    vectors++;
    if (bus.memory_dout !== 32'h3FFF0000) begin
      miscompares++;
      $display("FAIL rstmid_readback_value: got %h want 3fff0000", bus.memory_dout);
    end
  endtask

  task automatic test_edge_addr();
    do_req(0, 1, 14'h3FFF, 32'hFFFFFFFF, "edge_wr_3fff");
    do_req(0, 0, 14'h3FFF, 32'h0, "edge_rd_3fff");
    do_req(0, 0, 14'h0000, 32'h0, "edge_rd_0000");
    vectors++;
    if (bus.memory_dout !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL edge_0000_value: got %h want 0badf00d", bus.memory_dout);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [8];
    logic [AW-1:0] a;
    int n;
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 8; i++) begin
        pool[i] = AW'($urandom_range(0, (1 << AW) - 1));
        do_req(z[0], 1, pool[i], $urandom, "rnd_fill");
      end
      n = (z == 0) ? 40 : 20;
      for (int i = 0; i < n; i++) begin
        a = pool[$urandom_range(0, 7)];
        if ($urandom_range(0, 2) == 0) do_req(z[0], 1, a, $urandom, "rnd_wr");
        else                           do_req(z[0], 0, a, 32'h0, "rnd_rd");
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_write_read();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_edge_addr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
